// File: rtl/rv_pipe_pkg.sv
// Shared fetch-pipeline types: bubble instruction, BHT counter encoding,
// IF/ID bundle layout and the saturating counter update.
package rv_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } ifid_t;

  function automatic ctr_e ctr_next(ctr_e c, logic taken);
    if (taken) return (c == ST) ? ST : ctr_e'(c + 2'd1);
    return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/fetch_predict_stage_if.sv
// Instruction-memory, EX-resolution and IF/ID bundle between the fetch stage
// (master) and the surrounding pipeline (slave).
interface fetch_predict_stage_if;
  import rv_pipe_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            update_e;
  logic [XLEN-1:0] pc_e;
  logic            is_jump_e;
  logic            taken_e;
  logic [XLEN-1:0] target_e;
  logic            redirect_e;
  logic [XLEN-1:0] redirect_pc_e;
  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4_d;
  logic            pred_taken_d;
  logic [XLEN-1:0] pred_target_d;

  modport master (
    output imem_addr, instr_d, pc_d, pc_plus4_d, pred_taken_d, pred_target_d,
    input  imem_rdata, update_e, pc_e, is_jump_e, taken_e, target_e,
           redirect_e, redirect_pc_e
  );

  modport slave (
    input  imem_addr, instr_d, pc_d, pc_plus4_d, pred_taken_d, pred_target_d,
    output imem_rdata, update_e, pc_e, is_jump_e, taken_e, target_e,
           redirect_e, redirect_pc_e
  );

endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry 2-bit counter: combinational lookup port
// and a single training write port driven by EX resolution.
module branch_target_buffer
  import rv_pipe_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_jump_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = XLEN - IDX_BITS - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  ctr_e               ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];

  logic [IDX_BITS-1:0] l_idx, u_idx;
  logic [TAG_W-1:0]    l_tag, u_tag;
  logic                l_hit, u_hit, u_write_tgt, u_alloc;
  logic                unused_pc_lsbs;

  assign unused_pc_lsbs = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign l_idx = lookup_pc_i[IDX_BITS+1:2];
  assign l_tag = lookup_pc_i[XLEN-1:IDX_BITS+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  assign pred_taken_o  = l_hit && (jump_q[l_idx] || (ctr_q[l_idx] inside {WT, ST}));
  assign pred_target_o = tgt_q[l_idx];

  assign u_idx = upd_pc_i[IDX_BITS+1:2];
  assign u_tag = upd_pc_i[XLEN-1:IDX_BITS+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Jumps always (re)write the target; conditional branches only when taken.
  assign u_write_tgt = upd_i && (upd_jump_i || upd_taken_i);
  assign u_alloc     = u_write_tgt && !u_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      jump_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
    end else if (upd_i) begin
      if (u_alloc) begin
        valid_q[u_idx] <= 1'b1;
        jump_q[u_idx]  <= upd_jump_i;
        ctr_q[u_idx]   <= WT;
      end else if (u_hit && upd_jump_i) begin
        jump_q[u_idx] <= 1'b1;
      end else if (u_hit) begin
        ctr_q[u_idx] <= ctr_next(ctr_q[u_idx], upd_taken_i);
      end
    end
  end

  // Tag and target are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (u_write_tgt) begin
      tgt_q[u_idx] <= upd_target_i;
      if (u_alloc) tag_q[u_idx] <= u_tag;
    end
  end

endmodule

// File: rtl/fetch_predict_stage.sv
// Instruction-fetch stage: PC register with BTB-driven next-PC prediction,
// EX redirect, and the IF/ID pipeline register feeding the decoder.
module fetch_predict_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IDX_BITS  = 4,
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_f,
  input  logic                  stall_d,
  input  logic                  flush_d,
  fetch_predict_stage_if.master bus
);
  import rv_pipe_pkg::*;

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0,
                               pred_taken: 1'b0, pred_target: '0};

  logic [XLEN-1:0] pcf_q, pcf_d, pcf_plus4;
  logic            pred_taken_f;
  logic [XLEN-1:0] pred_target_f;
  ifid_t           ifid_q, ifid_d;

  assign pcf_plus4     = pcf_q + 32'd4;
  assign bus.imem_addr = pcf_q;

  branch_target_buffer #(.IDX_BITS(IDX_BITS)) u_btb (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_pc_i  (pcf_q),
    .pred_taken_o (pred_taken_f),
    .pred_target_o(pred_target_f),
    .upd_i        (bus.update_e),
    .upd_pc_i     (bus.pc_e),
    .upd_jump_i   (bus.is_jump_e),
    .upd_taken_i  (bus.taken_e),
    .upd_target_i (bus.target_e)
  );

  // A mispredict redirect must win over a fetch stall, or the wrong path keeps running.
  always_comb begin
    pcf_d = pcf_plus4;
    if (bus.redirect_e)    pcf_d = bus.redirect_pc_e;
    else if (stall_f)      pcf_d = pcf_q;
    else if (pred_taken_f) pcf_d = pred_target_f;
  end

  always_comb begin
    ifid_d = ifid_q;
    if (flush_d) begin
      ifid_d = BUBBLE;
    end else if (!stall_d) begin
      ifid_d = '{instr: bus.imem_rdata, pc: pcf_q, pc_plus4: pcf_plus4,
                 pred_taken: pred_taken_f, pred_target: pred_target_f};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_q  <= RESET_PC;
      ifid_q <= BUBBLE;
    end else begin
      pcf_q  <= pcf_d;
      ifid_q <= ifid_d;
    end
  end

  assign bus.instr_d       = ifid_q.instr;
  assign bus.pc_d          = ifid_q.pc;
  assign bus.pc_plus4_d    = ifid_q.pc_plus4;
  assign bus.pred_taken_d  = ifid_q.pred_taken;
  assign bus.pred_target_d = ifid_q.pred_target;

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Bench for fetch_predict_stage: directed vector table with hand-derived PCs,
// then randomized traffic against a behavioural BTB/pipeline model.
module tb_fetch_predict_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n, stall_f, stall_d, flush_d;
  int   n_pass = 0, n_tot = 0, cyc = 0;

  fetch_predict_stage_if bus();

  fetch_predict_stage #(.RESET_PC(32'h0), .IDX_BITS(4), .NOP_INSTR(NOP)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .stall_f(stall_f),
    .stall_d(stall_d),
    .flush_d(flush_d),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  assign bus.imem_rdata = imem_word(bus.imem_addr);

  // Behavioural reference
  typedef struct {
    bit          v;
    logic [31:0] tag;
    logic [31:0] tgt;
    bit          j;
    int          ctr;
  } ent_t;

  ent_t        m_btb [16];
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_ptgt;
  bit          m_ptd;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s cyc=%0d: got %h, want %h", nm, cyc, act, exp);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 16; i++) begin
      m_btb[i].v   = 0;
      m_btb[i].ctr = 1;
      m_btb[i].j   = 0;
      m_btb[i].tag = '0;
      m_btb[i].tgt = '0;
    end
    m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_ptd = 0; m_ptgt = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_instr_d", bus.instr_d, NOP);
    chk("rst_pc_d", bus.pc_d, 32'h0);
    chk("rst_pc_plus4_d", bus.pc_plus4_d, 32'h0);
    chk("rst_pred_taken_d", {31'b0, bus.pred_taken_d}, 32'h0);
    chk("rst_pred_target_d", bus.pred_target_d, 32'h0);
  endtask

  // Compare against the model, then advance the model using the inputs of this cycle.
  task automatic model_cycle();
    int unsigned li, ui;
    bit          hit, pt, uh;
    logic [31:0] ptgt;
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("instr_d", bus.instr_d, m_instr);
    chk("pc_d", bus.pc_d, m_pcd);
    chk("pc_plus4_d", bus.pc_plus4_d, m_pc4d);
    chk("pred_taken_d", {31'b0, bus.pred_taken_d}, {31'b0, m_ptd});
    if (m_ptd) chk("pred_target_d", bus.pred_target_d, m_ptgt);

    li   = (m_pc / 4) % 16;
    hit  = m_btb[li].v && (m_btb[li].tag == m_pc / 64);
    pt   = hit && (m_btb[li].j || m_btb[li].ctr >= 2);
    ptgt = m_btb[li].tgt;

    if (flush_d) begin
      m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_ptd = 0; m_ptgt = 0;
    end else if (!stall_d) begin
      m_instr = imem_word(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 32'd4;
      m_ptd = pt; m_ptgt = ptgt;
    end

    if (bus.redirect_e)  m_pc = bus.redirect_pc_e;
    else if (stall_f)    m_pc = m_pc;
    else if (pt)         m_pc = ptgt;
    else                 m_pc = m_pc + 32'd4;

    if (bus.update_e) begin
      ui = (bus.pc_e / 4) % 16;
      uh = m_btb[ui].v && (m_btb[ui].tag == bus.pc_e / 64);
      if (bus.is_jump_e || (bus.taken_e && !uh)) begin
        if (!uh) begin
          m_btb[ui].v = 1; m_btb[ui].tag = bus.pc_e / 64; m_btb[ui].ctr = 2;
          m_btb[ui].j = bus.is_jump_e;
        end else begin
          m_btb[ui].j = 1;
        end
        m_btb[ui].tgt = bus.target_e;
      end else if (uh) begin
        if (bus.taken_e) begin
          m_btb[ui].ctr = (m_btb[ui].ctr == 3) ? 3 : m_btb[ui].ctr + 1;
          m_btb[ui].tgt = bus.target_e;
        end else begin
          m_btb[ui].ctr = (m_btb[ui].ctr == 0) ? 0 : m_btb[ui].ctr - 1;
        end
      end
    end
  endtask

  typedef struct {
    bit sf, sd, fl, upd, jmp, tk;
    logic [31:0] pce, tge;
    bit rd;
    logic [31:0] rdpc, exp_pcf, exp_pcd;
    bit exp_ptd;
  } vec_t;

  function automatic vec_t mk(bit sf, bit sd, bit fl, bit upd, bit jmp, bit tk,
                              logic [31:0] pce, logic [31:0] tge, bit rd,
                              logic [31:0] rdpc, logic [31:0] epcf,
                              logic [31:0] epcd, bit eptd);
    vec_t r;
    r.sf = sf; r.sd = sd; r.fl = fl; r.upd = upd; r.jmp = jmp; r.tk = tk;
    r.pce = pce; r.tge = tge; r.rd = rd; r.rdpc = rdpc;
    r.exp_pcf = epcf; r.exp_pcd = epcd; r.exp_ptd = eptd;
    return r;
  endfunction

  task automatic apply(vec_t r);
    stall_f = r.sf; stall_d = r.sd; flush_d = r.fl;
    bus.update_e = r.upd; bus.is_jump_e = r.jmp; bus.taken_e = r.tk;
    bus.pc_e = r.pce; bus.target_e = r.tge;
    bus.redirect_e = r.rd; bus.redirect_pc_e = r.rdpc;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  vec_t tbl [25];
  vec_t rv;

  initial begin
    // Each row: inputs for the cycle, then expected PCF / pc_d / pred_taken_d seen in it.
    tbl[0]  = mk(0,0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,        32'h0,        32'h0,        0);
    tbl[1]  = mk(0,0,0, 1,0,1, 32'h40,  32'h80,  0, 32'h0,        32'h4,        32'h0,        0);
    tbl[2]  = mk(0,0,1, 0,0,0, 32'h0,   32'h0,   1, 32'h40,       32'h8,        32'h4,        0);
    tbl[3]  = mk(0,0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,        32'h40,       32'h0,        0);
    tbl[4]  = mk(0,0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,        32'h80,       32'h40,       1);
    tbl[5]  = mk(0,0,0, 1,0,0, 32'h40,  32'h0,   0, 32'h0,        32'h84,       32'h80,       0);
    tbl[6]  = mk(0,0,0, 1,0,0, 32'h40,  32'h0,   0, 32'h0,        32'h88,       32'h84,       0);
    tbl[7]  = mk(0,0,1, 1,0,0, 32'h40,  32'h0,   1, 32'h40,       32'h8C,       32'h88,       0);
    tbl[8]  = mk(0,0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,        32'h40,       32'h0,        0);
    tbl[9]  = mk(0,0,1, 1,1,0, 32'h10,  32'h200, 1, 32'h10,       32'h44,       32'h40,       0);
    tbl[10] = mk(0,0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,        32'h10,       32'h0,        0);
    tbl[11] = mk(0,0,1, 0,0,0, 32'h0,   32'h0,   1, 32'h410,      32'h200,      32'h10,       1);
    tbl[12] = mk(0,0,0, 1,0,0, 32'h10,  32'h0,   0, 32'h0,        32'h410,      32'h0,        0);
    tbl[13] = mk(0,0,1, 1,0,0, 32'h10,  32'h0,   1, 32'h10,       32'h414,      32'h410,      0);
    tbl[14] = mk(0,0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,        32'h10,       32'h0,        0);
    tbl[15] = mk(1,1,1, 0,0,0, 32'h0,   32'h0,   1, 32'h300,      32'h200,      32'h10,       1);
    tbl[16] = mk(1,1,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,        32'h300,      32'h0,        0);
    tbl[17] = mk(0,0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,        32'h300,      32'h0,        0);
    tbl[18] = mk(0,0,0, 1,0,1, 32'h304, 32'h500, 0, 32'h0,        32'h304,      32'h300,      0);
    tbl[19] = mk(0,0,1, 0,0,0, 32'h0,   32'h0,   1, 32'h304,      32'h308,      32'h304,      0);
    tbl[20] = mk(0,0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,        32'h304,      32'h0,        0);
    tbl[21] = mk(0,0,1, 0,0,0, 32'h0,   32'h0,   1, 32'hFFFF_FFFC, 32'h500,      32'h304,      1);
    tbl[22] = mk(0,0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,        32'hFFFF_FFFC, 32'h0,       0);
    tbl[23] = mk(0,0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,        32'h0,        32'hFFFF_FFFC, 0);
    tbl[24] = mk(0,0,0, 0,0,0, 32'h0,   32'h0,   0, 32'h0,        32'h4,        32'h0,        0);

    rst_n = 1'b0;
    rv = mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0, 0);
    apply(rv);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("tbl%0d_pcf", i), bus.imem_addr, tbl[i].exp_pcf);
      chk($sformatf("tbl%0d_pc_d", i), bus.pc_d, tbl[i].exp_pcd);
      chk($sformatf("tbl%0d_pred_taken_d", i), {31'b0, bus.pred_taken_d},
          {31'b0, tbl[i].exp_ptd});
      model_cycle();
      @(posedge clk);
      #1;
      cyc++;
    end

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst_n = 1'b0;
        #2;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      stall_f = ($urandom_range(0, 5) == 0);
      stall_d = ($urandom_range(0, 5) == 0);
      bus.redirect_e = ($urandom_range(0, 7) == 0);
      flush_d = bus.redirect_e || ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       bus.redirect_pc_e = 32'h40;
        1:       bus.redirect_pc_e = 32'h10;
        2:       bus.redirect_pc_e = 32'h304;
        default: bus.redirect_pc_e = 32'($urandom_range(0, 255)) * 4;
      endcase
      bus.update_e  = ($urandom_range(0, 2) == 0);
      bus.is_jump_e = ($urandom_range(0, 4) == 0);
      bus.taken_e   = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0:       bus.pc_e = 32'h40;
        1:       bus.pc_e = 32'h440;
        2:       bus.pc_e = 32'h10;
        3:       bus.pc_e = 32'h410;
        4:       bus.pc_e = 32'h304;
        default: bus.pc_e = 32'($urandom_range(0, 127)) * 4;
      endcase
      bus.target_e = 32'($urandom_range(0, 255)) * 4;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
